// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared constants and types for the execute stage
package exec_pkg;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  typedef enum logic [1:0] {IDLE, RUN, DONE} md_state_t;

  // mult/multu/div/divu occupy 0x18..0x1B, so the low two bits select the op
  function automatic logic is_md(input logic [5:0] fn);
    return fn[5:2] == FN_MULT[5:2];
  endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - single-cycle integer ALU
// Register-register MIPS ALU; unknown functions produce zero.
module alu #(
  parameter int W      = 32,
  parameter int FUNC_W = 6
) (
  input  logic [FUNC_W-1:0] func,
  input  logic [W-1:0]      a,
  input  logic [W-1:0]      b,
  output logic [W-1:0]      y
);

  localparam int SH = $clog2(W);

  always_comb begin
    y = '0;
    case (func)
      FUNC_W'(6'h20), FUNC_W'(6'h21): y = a + b;
      FUNC_W'(6'h22), FUNC_W'(6'h23): y = a - b;
      FUNC_W'(6'h24): y = a & b;
      FUNC_W'(6'h25): y = a | b;
      FUNC_W'(6'h26): y = a ^ b;
      FUNC_W'(6'h27): y = ~(a | b);
      FUNC_W'(6'h2A): y = W'($signed(a) < $signed(b));
      FUNC_W'(6'h2B): y = W'(a < b);
      FUNC_W'(6'h04): y = b << a[SH-1:0];
      FUNC_W'(6'h06): y = b >> a[SH-1:0];
      FUNC_W'(6'h07): y = $unsigned($signed(b) >>> a[SH-1:0]);
      default:        y = '0;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative multiply/divide with HI/LO registers
// Shift-add multiply and restoring divide on magnitudes, one bit per cycle.
module muldiv_unit
  import exec_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         flush,
  input  logic         stall,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  localparam int CW = $clog2(W) + 1;

  md_state_t      state;
  logic [W-1:0]   acc, q, m;
  logic [CW-1:0]  count;
  logic           is_div, neg_q, neg_r, div_zero;
  logic           a_neg, b_neg;
  logic [W-1:0]   a_mag, b_mag, nxt_acc, nxt_q, quot, rem;
  logic [W:0]     mul_sum, div_sh, div_diff;
  logic [2*W-1:0] prod;

  always_comb begin
    a_neg    = ~op[0] & a[W-1];
    b_neg    = ~op[0] & b[W-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    mul_sum  = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
    div_sh   = {acc, q[W-1]};
    div_diff = div_sh - {1'b0, m};
    if (is_div) begin
      nxt_acc = div_diff[W] ? div_sh[W-1:0] : div_diff[W-1:0];
      nxt_q   = {q[W-2:0], ~div_diff[W]};
    end else begin
      nxt_acc = mul_sum[W:1];
      nxt_q   = {mul_sum[0], q[W-1:1]};
    end
    prod = neg_q ? -{nxt_acc, nxt_q} : {nxt_acc, nxt_q};
    quot = div_zero ? '1 : (neg_q ? -nxt_q : nxt_q);
    rem  = neg_r ? -nxt_acc : nxt_acc;
  end

  assign busy = ((state == IDLE) & start) | (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      acc      <= '0;
      q        <= '0;
      m        <= '0;
      count    <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state    <= RUN;
          count    <= CW'(W);
          acc      <= '0;
          q        <= a_mag;
          m        <= b_mag;
          is_div   <= op[1];
          neg_q    <= a_neg ^ b_neg;
          neg_r    <= a_neg;
          div_zero <= (b == '0);
        end
        RUN: if (flush) begin
          state <= IDLE;
        end else begin
          acc   <= nxt_acc;
          q     <= nxt_q;
          count <= count - CW'(1);
          // last iteration: commit the sign-corrected result straight from the step logic
          if (count == CW'(1)) begin
            state <= DONE;
            if (is_div) begin
              hi <= rem;
              lo <= quot;
            end else begin
              {hi, lo} <= prod;
            end
          end
        end
        DONE: if (!stall || flush) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/execute_stage_md.sv
// rtl/execute_stage_md.sv - execute stage with forwarding, ALU and multiply/divide
// Holds the E register while stalled or while a multiply/divide is running.
module execute_stage_md
  import exec_pkg::*;
#(
  parameter int W      = 32,
  parameter int CTRL_W = 13,
  parameter int FUNC_W = 6,
  parameter int PASS_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_in,
  input  logic              flush_in,
  input  logic              valid_in,
  input  logic [CTRL_W-1:0] bundle_in,
  input  logic [W-1:0]      pc_seq_in,
  input  logic [W-1:0]      a_in,
  input  logic [W-1:0]      b_in,
  input  logic [1:0]        fwd_sel_a,
  input  logic [1:0]        fwd_sel_b,
  input  logic [W-1:0]      fwd_mem_in,
  input  logic [W-1:0]      fwd_wb_in,
  output logic              valid_out,
  output logic [PASS_W-1:0] bundle_out,
  output logic [W-1:0]      pc_seq_out,
  output logic [W-1:0]      alu_out,
  output logic              busy_out
);

  logic              valid_e, hold, md_op, md_req, busy, done;
  logic [CTRL_W-1:0] bundle_e;
  logic [W-1:0]      pc_e, a_e, b_e, op_a, op_b, alu_y, hi, lo;
  logic [FUNC_W-1:0] func;

  assign func   = bundle_e[CTRL_W-1 -: FUNC_W];
  assign md_op  = is_md(6'(func));
  assign md_req = valid_e & md_op & ~flush_in;
  assign hold   = stall_in | busy;

  always_comb begin
    case (fwd_sel_a)
      FWD_MEM: op_a = fwd_mem_in;
      FWD_WB:  op_a = fwd_wb_in;
      default: op_a = a_e;
    endcase
    case (fwd_sel_b)
      FWD_MEM: op_b = fwd_mem_in;
      FWD_WB:  op_b = fwd_wb_in;
      default: op_b = b_e;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_e  <= 1'b0;
      bundle_e <= '0;
      pc_e     <= '0;
      a_e      <= '0;
      b_e      <= '0;
    end else begin
      if (flush_in)   valid_e <= 1'b0;
      else if (!hold) valid_e <= valid_in;
      if (!hold) begin
        bundle_e <= bundle_in;
        pc_e     <= pc_seq_in;
        a_e      <= a_in;
        b_e      <= b_in;
      end
    end
  end

  alu #(.W(W), .FUNC_W(FUNC_W)) u_alu (
    .func (func),
    .a    (op_a),
    .b    (op_b),
    .y    (alu_y)
  );

  muldiv_unit #(.W(W)) u_muldiv (
    .clk   (clk),
    .reset (reset),
    .start (md_req),
    .flush (flush_in),
    .stall (stall_in),
    .op    (func[1:0]),
    .a     (op_a),
    .b     (op_b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always_comb begin
    alu_out = alu_y;
    if (func == FUNC_W'(FN_MFHI))      alu_out = hi;
    else if (func == FUNC_W'(FN_MFLO)) alu_out = lo;
    else if (md_op)                    alu_out = '0;
  end

  assign busy_out   = busy;
  assign valid_out  = valid_e & (done | ~busy);
  assign bundle_out = bundle_e[PASS_W-1:0];
  assign pc_seq_out = pc_e;

endmodule

// File: tb/tb_execute_stage_md.sv
// tb/tb_execute_stage_md.sv - self-checking bench for execute_stage_md
module tb_execute_stage_md;

  localparam logic [5:0] F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23;
  localparam logic [5:0] F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27;
  localparam logic [5:0] F_SLT = 6'h2A, F_SLTU = 6'h2B, F_SLLV = 6'h04, F_SRLV = 6'h06, F_SRAV = 6'h07;
  localparam logic [5:0] F_MFHI = 6'h10, F_MFLO = 6'h12;
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;

  logic        clk, reset, stall_in, flush_in, valid_in;
  logic [12:0] bundle_in;
  logic [31:0] pc_seq_in, a_in, b_in, fwd_mem_in, fwd_wb_in;
  logic [1:0]  fwd_sel_a, fwd_sel_b;
  logic        valid_out, busy_out;
  logic [6:0]  bundle_out;
  logic [31:0] pc_seq_out, alu_out;

  int checks = 0;
  int errors = 0;

  execute_stage_md dut (
    .clk        (clk),
    .reset      (reset),
    .stall_in   (stall_in),
    .flush_in   (flush_in),
    .valid_in   (valid_in),
    .bundle_in  (bundle_in),
    .pc_seq_in  (pc_seq_in),
    .a_in       (a_in),
    .b_in       (b_in),
    .fwd_sel_a  (fwd_sel_a),
    .fwd_sel_b  (fwd_sel_b),
    .fwd_mem_in (fwd_mem_in),
    .fwd_wb_in  (fwd_wb_in),
    .valid_out  (valid_out),
    .bundle_out (bundle_out),
    .pc_seq_out (pc_seq_out),
    .alu_out    (alu_out),
    .busy_out   (busy_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    case (fn)
      F_ADD, F_ADDU: return a + b;
      F_SUB, F_SUBU: return a - b;
      F_AND:  return a & b;
      F_OR:   return a | b;
      F_XOR:  return a ^ b;
      F_NOR:  return ~(a | b);
      F_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      F_SLTU: return (a < b) ? 32'd1 : 32'd0;
      F_SLLV: return b << a[4:0];
      F_SRLV: return b >> a[4:0];
      F_SRAV: return $unsigned($signed(b) >>> a[4:0]);
      default: return 32'd0;
    endcase
  endfunction

  // {HI, LO} from plain integer arithmetic
  function automatic logic [63:0] md_ref(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (fn)
      F_MULT:  return 64'(sa * sb);
      F_MULTU: return {32'd0, a} * {32'd0, b};
      F_DIV:   if (b == 0) return {a, 32'hFFFF_FFFF};
               else return {32'(sa % sb), 32'(sa / sb)};
      F_DIVU:  if (b == 0) return {a, 32'hFFFF_FFFF};
               else return {a % b, a / b};
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] lat,
                                       input logic [31:0] mem, input logic [31:0] wb);
    return (sel == 2'd1) ? mem : (sel == 2'd2) ? wb : lat;
  endfunction

  // reference: E slot contents, remaining RUN cycles, pending result, DONE flag
  logic        m_valid, m_done;
  logic [12:0] m_bundle;
  logic [31:0] m_pc, m_a, m_b, m_hi, m_lo, p_hi, p_lo;
  int          m_left;

  always @(negedge clk) begin
    logic [5:0]  fn;
    logic        md, e_busy, e_valid, hold;
    logic [31:0] oa, ob, e_alu;
    if (!reset) begin
      m_valid = 0; m_done = 0; m_bundle = 0; m_pc = 0; m_a = 0; m_b = 0;
      m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0; m_left = 0;
    end
    fn      = m_bundle[12:7];
    md      = fn inside {[F_MULT:F_DIVU]};
    oa      = pick(fwd_sel_a, m_a, fwd_mem_in, fwd_wb_in);
    ob      = pick(fwd_sel_b, m_b, fwd_mem_in, fwd_wb_in);
    e_busy  = (m_left > 0) || (!m_done && m_valid && md && !flush_in);
    e_valid = m_valid && !e_busy;
    e_alu   = (fn == F_MFHI) ? m_hi : (fn == F_MFLO) ? m_lo : md ? 32'd0 : alu_ref(fn, oa, ob);
    check("valid_out", 32'(valid_out), 32'(e_valid));
    check("busy_out", 32'(busy_out), 32'(e_busy));
    check("alu_out", alu_out, e_alu);
    check("bundle_out", 32'(bundle_out), 32'(m_bundle[6:0]));
    check("pc_seq_out", pc_seq_out, m_pc);
    if (reset) begin
      hold = stall_in || e_busy;
      if (m_left > 0) begin
        if (flush_in) m_left = 0;
        else begin
          m_left--;
          if (m_left == 0) begin
            m_hi = p_hi; m_lo = p_lo; m_done = 1;
          end
        end
      end else if (m_done) begin
        if (!stall_in || flush_in) m_done = 0;
      end else if (m_valid && md && !flush_in) begin
        m_left = 32;
        {p_hi, p_lo} = md_ref(fn, oa, ob);
      end
      if (flush_in) m_valid = 0;
      else if (!hold) m_valid = valid_in;
      if (!hold) begin
        m_bundle = bundle_in; m_pc = pc_seq_in; m_a = a_in; m_b = b_in;
      end
    end
  end

  // present an instruction and keep it until E accepts it; returns at posedge+1 after the load
  task automatic issue(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    bit acc;
    valid_in  = 1;
    bundle_in = {fn, 7'($urandom)};
    pc_seq_in = $urandom;
    a_in = a;
    b_in = b;
    acc = 0;
    for (int n = 0; n < 100 && !acc; n++) begin
      @(negedge clk);
      acc = !busy_out && !stall_in;
      @(posedge clk); #1;
    end
    if (!acc) begin
      errors++;
      $display("FAIL issue_timeout fn=%h", fn);
    end
    valid_in = 0;
  endtask

  // returns on the first negedge with busy_out low
  task automatic wait_idle(input string nm, output int n);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!busy_out) return;
      n++;
    end
    errors++;
    $display("FAIL %s_timeout busy_cycles=%0d", nm, n);
  endtask

  task automatic read_hilo(input string nm, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    issue(F_MFHI, 0, 0);
    @(negedge clk); check({nm, "_hi"}, alu_out, exp_hi);
    @(posedge clk); #1;
    issue(F_MFLO, 0, 0);
    @(negedge clk); check({nm, "_lo"}, alu_out, exp_lo);
    @(posedge clk); #1;
  endtask

  task automatic md_run(input string nm, input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    issue(fn, a, b);
    wait_idle(nm, n);
    check({nm, "_busy_cycles"}, 32'(n), 32'd33);
    @(posedge clk); #1;
    read_hilo(nm, exp_hi, exp_lo);
  endtask

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 3))
      0: return 32'd0;
      1: return 32'($urandom_range(0, 20));
      2: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  logic [5:0] alu_tab [13] = '{F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
                               F_SLT, F_SLTU, F_SLLV, F_SRLV, F_SRAV};

  initial begin
    int n, r;
    logic [5:0] fn;
    clk = 0; reset = 0; stall_in = 0; flush_in = 0; valid_in = 0;
    bundle_in = 0; pc_seq_in = 0; a_in = 0; b_in = 0;
    fwd_sel_a = 0; fwd_sel_b = 0; fwd_mem_in = 0; fwd_wb_in = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_busy", 32'(busy_out), 32'd0);
    check("rst_alu", alu_out, 32'd0);
    check("rst_pc", pc_seq_out, 32'd0);
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;

    issue(F_ADD, 5, 7);
    fwd_sel_a = 2'd1; fwd_mem_in = 10;
    @(negedge clk);
    check("add_fwd_alu", alu_out, 32'd17);
    check("add_fwd_valid", 32'(valid_out), 32'd1);
    @(posedge clk); #1;
    fwd_sel_a = 0;

    issue(F_MULT, -32'sd3, 32'd5);
    wait_idle("mult", n);
    check("mult_busy_cycles", 32'(n), 32'd33);
    check("mult_done_valid", 32'(valid_out), 32'd1);
    @(posedge clk); #1;
    read_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFF1);

    md_run("divu", F_DIVU, 100, 7, 32'd2, 32'd14);
    md_run("div", F_DIV, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    md_run("divu0", F_DIVU, 9, 0, 32'd9, 32'hFFFF_FFFF);
    md_run("multu", F_MULTU, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE);

    // flush in the middle of a divide leaves HI/LO alone
    issue(F_DIVU, 100, 3);
    repeat (10) @(posedge clk);
    #1 flush_in = 1;
    @(posedge clk); #1;
    flush_in = 0;
    @(negedge clk);
    check("flush_busy", 32'(busy_out), 32'd0);
    check("flush_valid", 32'(valid_out), 32'd0);
    @(posedge clk); #1;
    read_hilo("flush", 32'd1, 32'hFFFF_FFFE);

    // stall at DONE with an mflo waiting in decode
    issue(F_MULT, 6, 7);
    stall_in = 1; valid_in = 1; bundle_in = {F_MFLO, 7'h15}; a_in = 0; b_in = 0;
    wait_idle("stall", n);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      check("stall_done_valid", 32'(valid_out), 32'd1);
      check("stall_done_alu", alu_out, 32'd0);
      @(posedge clk); #1;
    end
    stall_in = 0;
    @(negedge clk);
    check("stall_release_alu", alu_out, 32'd0);
    @(posedge clk); #1;
    valid_in = 0;
    @(negedge clk);
    check("stall_mflo", alu_out, 32'd42);
    check("stall_mflo_valid", 32'(valid_out), 32'd1);
    @(posedge clk); #1;

    // asynchronous reset in the middle of a multiply
    issue(F_MULT, 7, 9);
    repeat (5) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check("rst_run_busy", 32'(busy_out), 32'd0);
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    read_hilo("rst_run", 32'd0, 32'd0);

    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 19);
      if (r < 12)      fn = alu_tab[$urandom_range(0, 12)];
      else if (r < 15) fn = (r[0]) ? F_MFHI : F_MFLO;
      else             fn = 6'(F_MULT + 6'($urandom_range(0, 3)));
      valid_in   = ($urandom_range(0, 3) != 0);
      bundle_in  = {fn, 7'($urandom)};
      pc_seq_in  = $urandom;
      a_in       = rand_op();
      b_in       = rand_op();
      fwd_sel_a  = 2'($urandom);
      fwd_sel_b  = 2'($urandom);
      fwd_mem_in = rand_op();
      fwd_wb_in  = rand_op();
      stall_in   = ($urandom_range(0, 7) == 0);
      flush_in   = ($urandom_range(0, 63) == 0);
      @(posedge clk); #1;
    end
    stall_in = 0; flush_in = 0; valid_in = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_stage_md.md
# execute_stage_md

Parametrised execute pipeline stage for the MIPS core. It latches control bundle, sequential PC and operands from decode, then applies MEM/WB operand forwarding and computes the single-cycle ALU result. It adds valid/stall/flush pipeline control and an iterative multiply/divide unit with HI/LO registers. It sits between decode and memory and stalls upstream while a multiply/divide is running.

## Interface
Parameters:
- W, 32: datapath width; must be even and at least 8.
- CTRL_W, 13: control bundle width.
- FUNC_W, 6: ALU function field width, taken from bundle[CTRL_W-1 -: FUNC_W].
- PASS_W, 7: bundle bits passed downstream, taken from bundle[PASS_W-1:0].

Ports:
- clk in 1: clock; all state changes on the rising edge.
- reset in 1: asynchronous, active-low; clears all state.
- stall_in in 1: downstream hold; the E register and the DONE state hold.
- flush_in in 1: kill the instruction in E.
- valid_in in 1: the decode slot holds a real instruction.
- bundle_in in CTRL_W: control bundle from decode.
- pc_seq_in in W: PC+4 from decode.
- a_in, b_in in W: operand values from the register file.
- fwd_sel_a, fwd_sel_b in 2: forwarding select. 0 = latched operand, 1 = fwd_mem_in, 2 = fwd_wb_in, 3 = latched operand.
- fwd_mem_in, fwd_wb_in in W: forwarded results.
- valid_out out 1: the E result is final this cycle.
- bundle_out out PASS_W: registered passthrough control bits.
- pc_seq_out out W: registered PC+4.
- alu_out out W: result.
- busy_out out 1: multiply/divide busy; decode must hold.

## Operation
- hold = stall_in | busy_out. When hold is low, the E register loads valid_in, bundle_in, pc_seq_in, a_in and b_in.
- flush_in clears valid_e on the next edge, overriding the load and hold.
- Operands: opA and opB are the forwarding-mux outputs, driven by the latched operands and the current fwd_sel.
- Non-multiply/divide funcs: alu_out = alu(func, opA, opB).
- mfhi (0x10) gives alu_out = HI.
- mflo (0x12) gives alu_out = LO.
- mult, multu, div and divu (0x18–0x1B) give alu_out = 0.
- Multiply/divide FSM states: IDLE, RUN, DONE.
  - IDLE→RUN when valid_e, the func is a multiply/divide op, and flush_in is low. On this transition the FSM latches the operand magnitudes and the sign flags (signed ops only) and sets count = W.
  - RUN iterates one bit per cycle, decrementing count. Multiply is shift-add. Divide is restoring.
  - RUN→DONE when count reaches 1. On this edge HI/LO are written with sign correction:
    - multiply: {HI,LO} = product.
    - divide: LO = quotient, HI = remainder; the remainder takes the sign of the dividend.
  - DONE→IDLE when stall_in is low. The E register loads the next instruction on the same edge.
  - flush_in in RUN: RUN→IDLE and HI/LO are unchanged.
- Divide by zero: LO = all ones, HI = dividend. The cycle count is unchanged.
- busy_out = (IDLE & valid_e & md_op & ~flush_in) | RUN.
- valid_out = valid_e & ~busy_out.
- Reset values:
  - valid_e, bundle, pc_seq, a, b, HI, LO and count: 0.
  - State: IDLE.
  - Outputs: 0, except alu_out, which is the ALU of zero operands with func 0.

## Timing
- ALU ops: one cycle from the E-register load to alu_out and valid_out.
- Multiply/divide: busy_out is high for exactly W+1 cycles (1 IDLE + W RUN). In the next cycle (DONE) valid_out = 1.
- An mfhi/mflo directly behind a multiply/divide is held in decode. It sees the new HI/LO once it enters E.
- stall_in while in DONE: the FSM stays in DONE and HI/LO are not rewritten.
- stall_in and flush_in together: flush wins.
- reset asserted mid-RUN: the FSM returns to IDLE immediately and HI/LO are zero.

## Structure
- Package exec_pkg holds:
  - the func constants: FN_MFHI, FN_MFLO, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU;
  - the md_state_t enum {IDLE, RUN, DONE};
  - the forwarding-select constants.
- Sub-module muldiv_unit contains the FSM, the iterative datapath and HI/LO. Its outputs are busy, done, hi and lo.
- The existing alu is instantiated unchanged.

## Test plan
- Reset: hold reset low, then release → all outputs 0, busy_out 0, FSM in IDLE.
- add with a_in=5, b_in=7 and fwd_sel_a=1, fwd_mem_in=10 → alu_out=17 and valid_out=1 one cycle after the load.
- mult with -3 and 5 at W=32 → busy_out high for 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1. A following mflo returns 0xFFFFFFF1.
- divu 100/7 → LO=14, HI=2. div -7/2 → LO=-3, HI=-1. divu 9/0 → LO=0xFFFFFFFF, HI=9.
- flush_in 10 cycles into a RUN → busy_out drops the next cycle, HI/LO keep their prior values, and valid_out stays 0.
- stall_in held 3 cycles at DONE → state stays DONE and valid_out stays 1. The next instruction loads only after stall_in falls.
